// File: rtl/series_accumulator.sv
// Sequential odd-power series evaluator: result = sum coef[k] * x^(2k+1) in signed Q5.10.
// Walks an external coefficient ROM one term per cycle and saturates the final sum.
module series_accumulator #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned FRAC   = 10,
    parameter int unsigned TERMS  = 7,
    parameter int unsigned ACC_W  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] x,
    output logic [2:0]        rom_sel,
    input  logic [DATA_W-1:0] coef,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              sat
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam logic signed [PROD_W-1:0] SatMax = {{(DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [PROD_W-1:0] SatMin = {{(DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};
    localparam logic [2:0] LastK = 3'(TERMS - 1);

    typedef enum logic [1:0] {StIdle, StSquare, StTerm, StDone} state_e;

    state_e                    state_q, state_d;
    logic [2:0]                k_q, k_d;
    logic signed [DATA_W-1:0]  x_q, x_d;
    logic signed [DATA_W-1:0]  xsq_q, xsq_d;
    logic signed [DATA_W-1:0]  p_q, p_d;
    logic signed [DATA_W-1:0]  result_q, result_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic                      sat_q, sat_d;

    logic signed [PROD_W-1:0]  sq_prod, sq_shr;
    logic signed [PROD_W-1:0]  term_prod, term_shr;
    logic signed [PROD_W-1:0]  pow_prod, pow_shr;
    logic signed [PROD_W-1:0]  acc_ext;

    function automatic logic signed [DATA_W-1:0] sat_fn(input logic signed [PROD_W-1:0] v);
        if (v > SatMax) begin
            return SatMax[DATA_W-1:0];
        end else if (v < SatMin) begin
            return SatMin[DATA_W-1:0];
        end
        return v[DATA_W-1:0];
    endfunction

    function automatic logic ovf_fn(input logic signed [PROD_W-1:0] v);
        return (v > SatMax) || (v < SatMin);
    endfunction

    // Arithmetic right shifts on signed operands floor toward -inf.
    assign sq_prod   = x_q * x_q;
    assign sq_shr    = sq_prod >>> FRAC;
    assign term_prod = $signed(coef) * p_q;
    assign term_shr  = term_prod >>> FRAC;
    assign pow_prod  = p_q * xsq_q;
    assign pow_shr   = pow_prod >>> FRAC;
    assign acc_ext   = PROD_W'(acc_q);

    assign busy    = (state_q != StIdle);
    assign done    = (state_q == StDone);
    assign rom_sel = (state_q == StTerm) ? k_q : 3'd0;
    // The final sum is presented during the done cycle itself, then held in result_q.
    assign result  = done ? sat_fn(acc_ext) : result_q;
    assign sat     = done ? ovf_fn(acc_ext) : sat_q;

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        x_d      = x_q;
        xsq_d    = xsq_q;
        p_d      = p_q;
        acc_d    = acc_q;
        result_d = result_q;
        sat_d    = sat_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    x_d     = x;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = StSquare;
                end
            end
            StSquare: begin
                xsq_d   = sat_fn(sq_shr);
                p_d     = x_q;
                state_d = StTerm;
            end
            StTerm: begin
                // The shifted term always fits ACC_W, so the truncating cast keeps its sign.
                acc_d = acc_q + ACC_W'(term_shr);
                p_d   = sat_fn(pow_shr);
                k_d   = k_q + 3'd1;
                if (k_q == LastK) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                result_d = sat_fn(acc_ext);
                sat_d    = ovf_fn(acc_ext);
                k_d      = '0;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            k_q      <= '0;
            x_q      <= '0;
            xsq_q    <= '0;
            p_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            x_q      <= x_d;
            xsq_q    <= xsq_d;
            p_q      <= p_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            sat_q    <= sat_d;
        end
    end

endmodule

// File: tb/tb_series_accumulator.sv
// Self-checking bench for series_accumulator: table of evaluations with a result scoreboard,
// plus hand-written reset-abort and start-while-busy sequences.
module tb_series_accumulator;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic signed [15:0] x;
    logic [2:0]         rom_sel;
    logic signed [15:0] coef;
    logic               busy;
    logic               done;
    logic signed [15:0] result;
    logic               sat;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic signed [15:0] r;
        logic               s;
    } exp_t;

    typedef struct {
        logic signed [15:0] xv;
        logic signed [15:0] r;
        logic               s;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[11];

    series_accumulator dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .x       (x),
        .rom_sel (rom_sel),
        .coef    (coef),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .sat     (sat)
    );

    always #5 clk = ~clk;

    function automatic logic signed [15:0] rom_val(input logic [2:0] s);
        case (s)
            3'd0:    return -16'sd1024;
            3'd1:    return -16'sd170;
            3'd2:    return -16'sd68;
            3'd3:    return -16'sd36;
            3'd4:    return -16'sd23;
            3'd5:    return -16'sd16;
            3'd6:    return -16'sd11;
            default: return 16'sd0;
        endcase
    endfunction

    always_comb coef = rom_val(rom_sel);

    function automatic longint sat_l(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic exp_t model(input logic signed [15:0] xv);
        exp_t   e;
        longint xl  = longint'(xv);
        longint xsq = sat_l((xl * xl) >>> 10);
        longint p   = xl;
        longint acc = 0;
        for (int k = 0; k < 7; k++) begin
            acc = acc + ((longint'(rom_val(3'(k))) * p) >>> 10);
            p   = sat_l((p * xsq) >>> 10);
        end
        e.r = 16'(sat_l(acc));
        e.s = (acc > 32767) || (acc < -32768);
        return e;
    endfunction

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Drives one start at cycle T, pushes the expectation, and compares when done appears.
    // glitch_at > 0 raises start again at that cycle offset, which must be ignored.
    task automatic run_eval(input logic signed [15:0] xv, input logic signed [15:0] er,
                            input logic es, input bit chk_sel, input int glitch_at);
        exp_t e;
        bit   seen = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b1;
        x     = xv;
        sb_q.push_back('{r: er, s: es});
        @(posedge clk);
        #1;
        start = 1'b0;
        x     = 16'($urandom);
        for (int lat = 1; lat <= 20; lat++) begin
            @(negedge clk);
            if (chk_sel && lat >= 1 && lat <= 9) begin
                check("rom_sel", 32'(rom_sel), (lat >= 2 && lat <= 8) ? lat - 2 : 0);
            end
            start = (lat == glitch_at);
            x     = 16'($urandom);
            if (done) begin
                seen = 1'b1;
                check("latency", lat, 9);
                check("busy_in_done", 32'(busy), 1);
                if (sb_q.size() == 0) begin
                    check("scoreboard_empty", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("result", result, e.r);
                    check("sat", 32'(sat), 32'(e.s));
                end
                break;
            end
        end
        if (!seen) check("done_timeout", 0, 1);
    endtask

    initial begin
        exp_t e;
        bit   saw_done;
        rst   = 1'b1;
        start = 1'b0;
        x     = '0;

        vecs[0] = '{xv: 16'sd0,      r: 16'sd0,     s: 1'b0};
        vecs[1] = '{xv: 16'sd1024,   r: -16'sd1348, s: 1'b0};
        vecs[2] = '{xv: -16'sd1024,  r: 16'sd1348,  s: 1'b0};
        vecs[3] = '{xv: 16'sd512,    r: -16'sd539,  s: 1'b0};
        vecs[4] = '{xv: -16'sd32768, r: 16'sd32767, s: 1'b1};
        for (int i = 5; i < 11; i++) begin
            vecs[i].xv = 16'($urandom);
            e          = model(vecs[i].xv);
            vecs[i].r  = e.r;
            vecs[i].s  = e.s;
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_result", result, 0);
        check("reset_sat", 32'(sat), 0);
        check("reset_rom_sel", 32'(rom_sel), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_eval(vecs[i].xv, vecs[i].r, vecs[i].s, (i == 0), 0);
        end

        // Result is held after the done pulse.
        @(negedge clk);
        check("done_pulse_width", 32'(done), 0);
        check("result_hold", result, vecs[10].r);

        // Saturating run leaves a non-zero result, so the reset clear below is observable.
        run_eval(-16'sd32768, 16'sd32767, 1'b1, 1'b0, 0);
        @(posedge clk);
        #1;
        start = 1'b1;
        x     = 16'sd1024;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 0);
        check("abort_result", result, 0);
        check("abort_sat", 32'(sat), 0);
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", 32'(saw_done), 0);

        // Start during busy is dropped, not queued.
        run_eval(16'sd512, -16'sd539, 1'b0, 1'b0, 4);
        @(posedge clk);
        #1;
        start = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy || done) saw_done = 1'b1;
        end
        check("ignored_start_not_queued", 32'(saw_done), 0);

        // Start held in DONE is ignored; back-to-back start at T+10 runs normally.
        run_eval(-16'sd1024, 16'sd1348, 1'b0, 1'b0, 9);
        run_eval(16'sd1024, -16'sd1348, 1'b0, 1'b1, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("scoreboard_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
